cmos_capture_win: RTL and testbench

Parametrised successor to the camera byte-stream capture stage. It takes a DVP-style sensor bus (vsync/href/din) and packs BPP bytes into one pixel. It adds a run-time crop window, frame decimation, single-shot or continuous mode, and line/frame integrity checking. It sits between the sensor interface and the frame-buffer/SDRAM write path and emits a vld/sop/eop pixel stream.

---
 rtl/cmos_cap_pkg.sv | 13 +
 rtl/cmos_beat_pack.sv | 44 ++++
 rtl/cmos_capture_win.sv | 231 +++++++++++++++++++++++
 tb/tb_cmos_capture_win.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cap_pkg.sv
// Shared constants for the DVP capture window: FSM encoding and line geometry helper.
package cmos_cap_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_VS = 2'd1;
   localparam logic [1:0] ST_ACTIVE  = 2'd2;

   // Bus beats in one complete sensor line (LINE_BEATS = COL*BPP).
   function automatic int line_beats(input int col, input int bpp);
      return col * bpp;
   endfunction

endpackage

// File: rtl/cmos_beat_pack.sv
// Shift-packer: assembles BPP sensor beats into one pixel, first beat in the MSBs.
module cmos_beat_pack #(
   parameter int DIN_W = 8,
   parameter int BPP   = 2,
   parameter int BW    = (BPP > 1) ? $clog2(BPP) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic [DIN_W-1:0]       din,
   output logic [DIN_W*BPP-1:0]   pix,
   output logic                   pix_done,
   output logic [BW-1:0]          beat
);

   localparam logic [BW-1:0] B_LAST = BW'(BPP - 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         beat     <= '0;
         pix_done <= 1'b0;
      end else begin
         pix_done <= en && (beat == B_LAST);
         if (en) begin
            beat <= (beat == B_LAST) ? '0 : beat + 1'b1;
         end
      end
   end

   // Data path carries no reset; pix is only consumed alongside pix_done.
   generate
      if (BPP == 1) begin : g_one
         always_ff @(posedge clk) begin
            if (en) pix <= din;
         end
      end else begin : g_shift
         always_ff @(posedge clk) begin
            if (en) pix <= {pix[DIN_W*(BPP-1)-1:0], din};
         end
      end
   endgenerate

endmodule

// File: rtl/cmos_capture_win.sv
// DVP byte-stream capture with run-time crop window, frame decimation,
// single-shot/continuous mode and line/frame integrity checking.
module cmos_capture_win
   import cmos_cap_pkg::*;
#(
   parameter int DIN_W = 8,
   parameter int BPP   = 2,
   parameter int COL   = 640,
   parameter int ROW   = 480,
   parameter int X_W   = 11,
   parameter int Y_W   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_capture,
   input  logic                  single_shot,
   input  logic [3:0]            skip_n,
   input  logic [X_W-1:0]        x_start,
   input  logic [Y_W-1:0]        y_start,
   input  logic [X_W-1:0]        win_w,
   input  logic [Y_W-1:0]        win_h,
   input  logic                  vsync,
   input  logic                  href,
   input  logic [DIN_W-1:0]      din,
   output logic [DIN_W*BPP-1:0]  dout,
   output logic                  dout_vld,
   output logic                  dout_sop,
   output logic                  dout_eop,
   output logic                  busy,
   output logic                  line_err,
   output logic                  frame_err,
   output logic                  cfg_err,
   output logic [15:0]           frame_cnt
);

   localparam int PIX_W      = DIN_W * BPP;
   localparam int LINE_BEATS = line_beats(COL, BPP);
   localparam int BC_W       = $clog2(LINE_BEATS + 1) + 1;
   localparam int BW         = (BPP > 1) ? $clog2(BPP) : 1;

   localparam logic [BW-1:0]   B_LAST  = BW'(BPP - 1);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(LINE_BEATS);
   localparam logic [BC_W-1:0] BC_MAX  = '1;
   localparam logic [Y_W-1:0]  Y_END   = Y_W'(ROW);

   logic [1:0]        state;
   logic              vs_d;
   logic              href_d;
   logic [3:0]        skip_cnt;
   logic              shot_done;

   logic [X_W-1:0]    xs_l;
   logic [X_W-1:0]    xl_l;
   logic [Y_W-1:0]    ys_l;
   logic [Y_W-1:0]    yl_l;
   logic              ss_l;

   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [BC_W-1:0]   bc;

   logic              fs;
   logic              le;
   logic              frame_abort;
   logic              start_evt;
   logic              active_cnt;
   logic              shift_en;
   logic              pix_now;
   logic              line_end;
   logic              in_win;

   logic [PIX_W-1:0]  pix;
   logic              pix_done;
   logic [BW-1:0]     beat;

   logic              win_p0;
   logic              sop_p0;
   logic              eop_p0;

   function automatic logic cfg_legal(input logic [X_W-1:0] xs, input logic [X_W-1:0] w,
                                      input logic [Y_W-1:0] ys, input logic [Y_W-1:0] h);
      logic [X_W:0] xe;
      logic [Y_W:0] ye;
      xe = {1'b0, xs} + {1'b0, w};
      ye = {1'b0, ys} + {1'b0, h};
      return (w != '0) && (h != '0) && (xe <= (X_W+1)'(COL)) && (ye <= (Y_W+1)'(ROW));
   endfunction

   assign fs          = vsync & ~vs_d;
   assign le          = href_d & ~href;
   assign frame_abort = fs && (state == ST_ACTIVE) && (y < Y_END);
   // A vsync rise is a frame start in WAIT_VS, when it cuts a frame short, or
   // when it lands exactly on the end of a continuous-mode frame.
   assign start_evt   = fs && ((state == ST_WAIT_VS) ||
                               ((state == ST_ACTIVE) && ((y < Y_END) || !ss_l)));
   assign active_cnt  = (state == ST_ACTIVE) && (y < Y_END) && !start_evt;
   assign shift_en    = active_cnt && href;
   assign pix_now     = shift_en && (beat == B_LAST);
   assign line_end    = active_cnt && le;
   assign in_win      = (x >= xs_l) && (x <= xl_l) && (y >= ys_l) && (y <= yl_l);
   assign busy        = (state == ST_ACTIVE);

   cmos_beat_pack #(
      .DIN_W (DIN_W),
      .BPP   (BPP),
      .BW    (BW)
   ) u_pack (
      .clk      (clk),
      .rst      (rst),
      .clr      (line_end || start_evt),
      .en       (shift_en),
      .din      (din),
      .pix      (pix),
      .pix_done (pix_done),
      .beat     (beat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         vs_d      <= 1'b0;
         href_d    <= 1'b0;
         skip_cnt  <= '0;
         shot_done <= 1'b0;
         xs_l      <= '0;
         xl_l      <= '0;
         ys_l      <= '0;
         yl_l      <= '0;
         ss_l      <= 1'b0;
         x         <= '0;
         y         <= '0;
         bc        <= '0;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         vs_d      <= vsync;
         href_d    <= href;
         line_err  <= 1'b0;
         cfg_err   <= 1'b0;
         frame_err <= frame_abort;
         if (!en_capture) shot_done <= 1'b0;

         if (start_evt) begin
            if (!en_capture) begin
               state <= ST_IDLE;
            end else if (skip_cnt != '0) begin
               skip_cnt <= skip_cnt - 4'd1;
               state    <= ST_WAIT_VS;
            end else if (!cfg_legal(x_start, win_w, y_start, win_h)) begin
               cfg_err <= 1'b1;
               state   <= ST_WAIT_VS;
            end else begin
               xs_l     <= x_start;
               xl_l     <= x_start + win_w - 1'b1;
               ys_l     <= y_start;
               yl_l     <= y_start + win_h - 1'b1;
               ss_l     <= single_shot;
               x        <= '0;
               y        <= '0;
               bc       <= '0;
               skip_cnt <= skip_n;
               state    <= ST_ACTIVE;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  if (en_capture && !shot_done) state <= ST_WAIT_VS;
               end
               ST_WAIT_VS: begin
                  state <= ST_WAIT_VS;
               end
               ST_ACTIVE: begin
                  if (y == Y_END) begin
                     if (ss_l || !en_capture) begin
                        state     <= ST_IDLE;
                        shot_done <= ss_l;
                     end else begin
                        state <= ST_WAIT_VS;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase

            if (shift_en) begin
               if (bc != BC_MAX) bc <= bc + 1'b1;
               if (pix_now) x <= x + 1'b1;
            end
            // Line still counts on a bad length; counters resync on the next href.
            if (line_end) begin
               y        <= y + 1'b1;
               x        <= '0;
               bc       <= '0;
               line_err <= (bc != BC_FULL) || (beat != '0);
            end
         end
      end
   end

   // Stage p0: window tag registered with the packed pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_p0 <= 1'b0;
         sop_p0 <= 1'b0;
         eop_p0 <= 1'b0;
      end else begin
         win_p0 <= pix_now && in_win;
         sop_p0 <= pix_now && in_win && (x == xs_l) && (y == ys_l);
         eop_p0 <= pix_now && in_win && (x == xl_l) && (y == yl_l);
      end
   end

   // Stage p1: output register; an aborted frame drops its in-flight pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout      <= '0;
         dout_vld  <= 1'b0;
         dout_sop  <= 1'b0;
         dout_eop  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         dout_vld <= pix_done && win_p0 && !frame_abort;
         dout_sop <= pix_done && win_p0 && sop_p0 && !frame_abort;
         dout_eop <= pix_done && win_p0 && eop_p0 && !frame_abort;
         if (pix_done && win_p0) dout <= pix;
         if (pix_done && win_p0 && eop_p0 && !frame_abort) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_cmos_capture_win.sv
// Scoreboard bench for cmos_capture_win on a small 8x4 sensor with 2 beats per pixel.
module tb_cmos_capture_win;

   localparam int DIN_W = 8;
   localparam int BPP   = 2;
   localparam int COL   = 8;
   localparam int ROW   = 4;
   localparam int X_W   = 11;
   localparam int Y_W   = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              en_capture;
   logic              single_shot;
   logic [3:0]        skip_n;
   logic [X_W-1:0]    x_start;
   logic [Y_W-1:0]    y_start;
   logic [X_W-1:0]    win_w;
   logic [Y_W-1:0]    win_h;
   logic              vsync;
   logic              href;
   logic [DIN_W-1:0]  din;
   logic [15:0]       dout;
   logic              dout_vld;
   logic              dout_sop;
   logic              dout_eop;
   logic              busy;
   logic              line_err;
   logic              frame_err;
   logic              cfg_err;
   logic [15:0]       frame_cnt;

   typedef struct {
      logic [15:0] d;
      logic        s;
      logic        e;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int n_line_err = 0;
   int n_frame_err = 0;
   int n_cfg_err = 0;
   int n_eop = 0;
   int n_sop = 0;

   cmos_capture_win #(
      .DIN_W(DIN_W), .BPP(BPP), .COL(COL), .ROW(ROW), .X_W(X_W), .Y_W(Y_W)
   ) dut (
      .clk(clk), .rst(rst), .en_capture(en_capture), .single_shot(single_shot),
      .skip_n(skip_n), .x_start(x_start), .y_start(y_start), .win_w(win_w), .win_h(win_h),
      .vsync(vsync), .href(href), .din(din), .dout(dout), .dout_vld(dout_vld),
      .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy), .line_err(line_err),
      .frame_err(frame_err), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_win(input int xs, input int ys, input int w, input int h);
      x_start = X_W'(xs);
      y_start = Y_W'(ys);
      win_w   = X_W'(w);
      win_h   = Y_W'(h);
   endtask

   task automatic push_pix(input int px, input int py, input int xs, input int ys,
                           input int w, input int h, input logic [15:0] d);
      exp_t e;
      if (px >= xs && px < xs + w && py >= ys && py < ys + h) begin
         e.d = d;
         e.s = (px == xs) && (py == ys);
         e.e = (px == xs + w - 1) && (py == ys + h - 1);
         q.push_back(e);
      end
   endtask

   // Drives one frame; line 2 carries short_beats beats. When cap is set the
   // expected window pixels are queued as their last beat is driven.
   task automatic frame(input int nlines, input int short_beats, input bit cap,
                        input int xs, input int ys, input int w, input int h);
      logic [7:0] b;
      vsync = 1'b1;
      repeat (2) tick();
      vsync = 1'b0;
      repeat (3) tick();
      for (int y = 0; y < nlines; y++) begin
         int nb = (y == 2) ? short_beats : COL * BPP;
         for (int k = 0; k < nb; k++) begin
            b    = 8'(y * COL * BPP + k);
            href = 1'b1;
            din  = b;
            if (cap && (k % 2 == 1)) push_pix(k / 2, y, xs, ys, w, h, {b - 8'd1, b});
            tick();
         end
         href = 1'b0;
         din  = '0;
         repeat (4) tick();
      end
      repeat (3) tick();
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (line_err)  n_line_err++;
         if (frame_err) n_frame_err++;
         if (cfg_err)   n_cfg_err++;
         if (dout_vld) begin
            if (dout_eop) n_eop++;
            if (dout_sop) n_sop++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_vld: dout=0x%0h sop=%0d eop=%0d, expected no pixel",
                        dout, dout_sop, dout_eop);
            end else begin
               e = q.pop_front();
               check("dout", 32'(dout), 32'(e.d));
               check("dout_sop", 32'(dout_sop), 32'(e.s));
               check("dout_eop", 32'(dout_eop), 32'(e.e));
            end
         end
      end
   endtask

   initial begin
      int eop0;
      int sop0;
      fork
         monitor_loop();
      join_none

      rst = 1'b1; en_capture = 1'b0; single_shot = 1'b0; skip_n = 4'd0;
      vsync = 1'b0; href = 1'b0; din = '0;
      set_win(0, 0, 8, 4);
      repeat (3) tick();
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_vld", 32'(dout_vld), 32'h0);
      check("rst_sop", 32'(dout_sop), 32'h0);
      check("rst_eop", 32'(dout_eop), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_errs", 32'({line_err, frame_err, cfg_err}), 32'h0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      rst = 1'b0;
      en_capture = 1'b1;
      repeat (2) tick();

      // Full window, bytes 0x00..0x3F.
      frame(4, 16, 1'b1, 0, 0, 8, 4);
      check("full_frame_cnt", 32'(frame_cnt), 32'd1);
      check("full_drained", 32'(q.size()), 32'd0);
      check("full_eops", 32'(n_eop), 32'd1);

      // Crop window.
      set_win(2, 1, 3, 2);
      frame(4, 16, 1'b1, 2, 1, 3, 2);
      check("crop_frame_cnt", 32'(frame_cnt), 32'd2);
      check("crop_drained", 32'(q.size()), 32'd0);

      // Decimation: capture frames 1, 4, 7 of seven.
      set_win(0, 0, 8, 4);
      skip_n = 4'd2;
      frame(4, 16, 1'b1, 0, 0, 8, 4);
      frame(4, 16, 1'b0, 0, 0, 8, 4);
      frame(4, 16, 1'b0, 0, 0, 8, 4);
      frame(4, 16, 1'b1, 0, 0, 8, 4);
      frame(4, 16, 1'b0, 0, 0, 8, 4);
      frame(4, 16, 1'b0, 0, 0, 8, 4);
      skip_n = 4'd0;
      frame(4, 16, 1'b1, 0, 0, 8, 4);
      check("decim_frame_cnt", 32'(frame_cnt), 32'd5);
      check("decim_eops", 32'(n_eop), 32'd5);

      // Single shot: one frame, then parked in IDLE while en_capture stays high.
      single_shot = 1'b1;
      frame(4, 16, 1'b1, 0, 0, 8, 4);
      check("single_frame_cnt", 32'(frame_cnt), 32'd6);
      check("single_busy", 32'(busy), 32'h0);
      frame(4, 16, 1'b0, 0, 0, 8, 4);
      check("single_idle_busy", 32'(busy), 32'h0);
      check("single_idle_cnt", 32'(frame_cnt), 32'd6);
      en_capture = 1'b0;
      single_shot = 1'b0;
      repeat (2) tick();
      en_capture = 1'b1;
      repeat (2) tick();

      // Short line 2 (14 beats).
      frame(4, 14, 1'b1, 0, 0, 8, 4);
      check("short_line_err", 32'(n_line_err), 32'd1);
      check("short_frame_cnt", 32'(frame_cnt), 32'd7);
      check("short_drained", 32'(q.size()), 32'd0);

      // Early vsync after 2 lines, then a full frame.
      sop0 = n_sop;
      eop0 = n_eop;
      frame(2, 16, 1'b1, 0, 0, 8, 4);
      frame(4, 16, 1'b1, 0, 0, 8, 4);
      check("early_frame_err", 32'(n_frame_err), 32'd1);
      check("early_frame_cnt", 32'(frame_cnt), 32'd8);
      check("early_sops", 32'(n_sop - sop0), 32'd2);
      check("early_eops", 32'(n_eop - eop0), 32'd1);
      check("early_drained", 32'(q.size()), 32'd0);

      // Illegal window: 6+4 > 8 columns.
      set_win(6, 0, 4, 4);
      frame(4, 16, 1'b0, 6, 0, 4, 4);
      check("cfg_err_pulses", 32'(n_cfg_err), 32'd1);
      check("cfg_busy", 32'(busy), 32'h0);
      check("cfg_frame_cnt", 32'(frame_cnt), 32'd8);

      // Reset in the middle of a frame.
      set_win(0, 1, 8, 3);
      frame(1, 16, 1'b1, 0, 1, 8, 3);
      check("midrst_busy_before", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_vld", 32'(dout_vld), 32'h0);
      check("midrst_dout", 32'(dout), 32'h0);
      check("midrst_flags", 32'({dout_sop, dout_eop, line_err, frame_err, cfg_err}), 32'h0);
      check("midrst_frame_cnt", 32'(frame_cnt), 32'h0);
      rst = 1'b0;
      repeat (5) tick();
      check("final_drained", 32'(q.size()), 32'd0);
      check("final_line_errs", 32'(n_line_err), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
